// File: rtl/mandelbrot_pixel_scheduler.sv
// Frame sequencer for the Mandelbrot pipeline.
// Walks the pixel grid in raster order, hands one coordinate at a time to the
// iteration core, captures its result (or a forced in-set result when the core
// stays silent too long) and offers it to the colour mapper under valid/ready.
// Every output is a register; a frame_done pulse marks the last accepted pixel.
module mandelbrot_pixel_scheduler #(
    parameter int H_RES   = 64,
    parameter int V_RES   = 48,
    parameter int COORD_W = 7,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         colour_mode_in,
    output logic               core_start,
    output logic [COORD_W-1:0] core_x,
    output logic [COORD_W-1:0] core_y,
    input  logic               core_done,
    input  logic [5:0]         core_iter,
    input  logic               core_in_set,
    output logic               map_valid,
    input  logic               map_ready,
    output logic [5:0]         map_iter,
    output logic               map_in_set,
    output logic [1:0]         colour_mode_out,
    output logic               busy,
    output logic               frame_done
);

    // Wait counter runs 0..TIMEOUT-1, one count per cycle spent in WAIT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_RES - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Result substituted when the core never answers: deepest count, in set.
    localparam logic [5:0] FORCED_ITER = 6'd63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;

    // Sequencer: state, coordinates, result capture and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            core_start      <= 1'b0;
            core_x          <= '0;
            core_y          <= '0;
            map_valid       <= 1'b0;
            map_iter        <= '0;
            map_in_set      <= 1'b0;
            colour_mode_out <= 2'd0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            // Both pulses are single-cycle unless re-armed below.
            core_start <= 1'b0;
            frame_done <= 1'b0;

            if (abort && (state_reg != IDLE)) begin
                // Abort beats start, core_done and map_ready; coordinates are
                // left as they were, the next start zeroes them anyway.
                state_reg <= IDLE;
                busy      <= 1'b0;
                map_valid <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            colour_mode_out <= colour_mode_in;
                            core_x          <= '0;
                            core_y          <= '0;
                            core_start      <= 1'b1;
                            busy            <= 1'b1;
                            state_reg       <= ISSUE;
                        end
                    end

                    ISSUE: begin
                        // core_start is visible during this state only.
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT;
                    end

                    WAIT: begin
                        // A real result on the final counted cycle still wins.
                        if (core_done) begin
                            map_iter   <= core_iter;
                            map_in_set <= core_in_set;
                            map_valid  <= 1'b1;
                            state_reg  <= EMIT;
                        end else if (wait_cnt_reg == CNT_LAST) begin
                            map_iter   <= FORCED_ITER;
                            map_in_set <= 1'b1;
                            map_valid  <= 1'b1;
                            state_reg  <= EMIT;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
                    end

                    EMIT: begin
                        // Data and coordinates hold until the mapper takes them.
                        if (map_ready) begin
                            map_valid <= 1'b0;
                            if (core_x != X_LAST) begin
                                core_x     <= core_x + 1'b1;
                                core_start <= 1'b1;
                                state_reg  <= ISSUE;
                            end else begin
                                core_x <= '0;
                                if (core_y != Y_LAST) begin
                                    core_y     <= core_y + 1'b1;
                                    core_start <= 1'b1;
                                    state_reg  <= ISSUE;
                                end else begin
                                    frame_done <= 1'b1;
                                    busy       <= 1'b0;
                                    state_reg  <= IDLE;
                                end
                            end
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        map_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
